// File: rtl/timer_sched.sv
// timer_sched: shares one 64-bit mtimecmp comparator among NCH software timer
// channels. It scans the armed channels for the earliest compare value and
// programs it into the timer with a HI/LO/HI write sequence. When int_timer
// fires, every armed channel that is due is latched into PEND.
//
// state   | meaning
// --------+-------------------------------------------------------------
// INIT    | after reset: preset cur_min to all-ones, then program it
// SCAN    | walk channels 0..NCH-1, tracking the earliest armed compare
// WR_HI1  | park mtimecmp high word at all-ones so no false match can occur
// WR_LO   | write cur_min[31:0] to mtimecmp low word
// WR_HI2  | write cur_min[63:32] to mtimecmp high word
// SETTLE1 | ignore int_timer while the timer's interrupt flop catches up
// SETTLE2 | second settle cycle
// WAIT    | idle; int_timer -> EXPIRE, otherwise a pending rescan -> SCAN
// EXPIRE  | move due channels from ARM to PEND, then rescan
module timer_sched #(
    parameter int          XLEN       = 32,
    parameter int          NCH        = 4,
    parameter logic [15:0] TMR_CMP_LO = 16'h4000,
    parameter logic [15:0] TMR_CMP_HI = 16'h4004
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            cfg_sel,
    input  logic [7:0]      cfg_addr,
    input  logic [3:0]      cfg_we,
    input  logic [XLEN-1:0] cfg_wdata,
    output logic [XLEN-1:0] cfg_rdata,
    output logic            m_sel,
    output logic [15:0]     m_addr,
    output logic [3:0]      m_we,
    output logic [XLEN-1:0] m_wdata,
    input  logic            int_timer,
    output logic            int_sched
);

    typedef enum logic [3:0] {
        INIT, SCAN, WR_HI1, WR_LO, WR_HI2, SETTLE1, SETTLE2, WAIT, EXPIRE
    } state_t;

    state_t                state_q, state_d;
    logic [2*XLEN-1:0]     cmp_q [NCH];
    logic [2*XLEN-1:0]     cmp_d [NCH];
    logic [NCH-1:0]        arm_q, arm_d, pend_q, pend_d, ien_q, ien_d;
    logic                  rescan_q, rescan_d;
    logic [2*XLEN-1:0]     cur_min_q, cur_min_d;
    logic                  found_q, found_d;
    logic [2:0]            cur_ch_q, cur_ch_d;
    logic [2:0]            scan_idx_q, scan_idx_d;
    logic                  m_sel_q, m_sel_d;
    logic [15:0]           m_addr_q, m_addr_d;
    logic [3:0]            m_we_q, m_we_d;
    logic [XLEN-1:0]       m_wdata_q, m_wdata_d;

    logic                  cfg_wr, wr_trig, busy;
    logic                  hit_cmp, hit_arm, hit_pend, hit_ien, hit_stat;
    logic                  sel_arm;
    logic [2*XLEN-1:0]     sel_cmp;
    logic                  unused_addr_bits;

    assign cfg_wr    = cfg_sel & (|cfg_we);
    assign hit_cmp   = (cfg_addr[7:3] < 5'(NCH));
    assign hit_arm   = (cfg_addr[7:2] == 6'h10);
    assign hit_pend  = (cfg_addr[7:2] == 6'h11);
    assign hit_ien   = (cfg_addr[7:2] == 6'h12);
    assign hit_stat  = (cfg_addr[7:2] == 6'h13);
    assign wr_trig   = cfg_wr & (hit_cmp | hit_arm);
    assign busy      = (state_q != WAIT);
    assign int_sched = |(pend_q & ien_q);
    assign unused_addr_bits = ^cfg_addr[1:0];

    assign m_sel   = m_sel_q;
    assign m_addr  = m_addr_q;
    assign m_we    = m_we_q;
    assign m_wdata = m_wdata_q;

    // Combinational register read mux; zero whenever the slave is not selected.
    always_comb begin
        cfg_rdata = '0;
        if (cfg_sel) begin
            for (int i = 0; i < NCH; i++) begin
                if (hit_cmp && cfg_addr[5:3] == 3'(i)) begin
                    cfg_rdata = cfg_addr[2] ? cmp_q[i][2*XLEN-1:XLEN] : cmp_q[i][XLEN-1:0];
                end
            end
            if (hit_arm)  cfg_rdata = XLEN'(arm_q);
            if (hit_pend) cfg_rdata = XLEN'(pend_q);
            if (hit_ien)  cfg_rdata = XLEN'(ien_q);
            if (hit_stat) begin
                cfg_rdata[XLEN-1] = busy;
                cfg_rdata[2:0]    = cur_ch_q;
            end
        end
    end

    // Next-state logic: software register writes first, then the FSM, so an
    // EXPIRE in the same cycle overrides software updates of ARM/PEND.
    always_comb begin
        cmp_d      = cmp_q;
        arm_d      = arm_q;
        pend_d     = pend_q;
        ien_d      = ien_q;
        state_d    = state_q;
        rescan_d   = rescan_q | wr_trig;
        cur_min_d  = cur_min_q;
        found_d    = found_q;
        cur_ch_d   = cur_ch_q;
        scan_idx_d = scan_idx_q;
        m_sel_d    = 1'b0;
        m_we_d     = 4'h0;
        m_addr_d   = m_addr_q;
        m_wdata_d  = m_wdata_q;
        sel_arm    = 1'b0;
        sel_cmp    = '0;

        if (cfg_wr) begin
            for (int i = 0; i < NCH; i++) begin
                if (hit_cmp && cfg_addr[5:3] == 3'(i)) begin
                    for (int b = 0; b < 4; b++) begin
                        if (cfg_we[b]) begin
                            if (cfg_addr[2]) cmp_d[i][XLEN+8*b +: 8] = cfg_wdata[8*b +: 8];
                            else             cmp_d[i][8*b +: 8]      = cfg_wdata[8*b +: 8];
                        end
                    end
                end
                if (hit_arm && cfg_we[i/8])                 arm_d[i]  = cfg_wdata[i];
                if (hit_ien && cfg_we[i/8])                 ien_d[i]  = cfg_wdata[i];
                if (hit_pend && cfg_we[i/8] && cfg_wdata[i]) pend_d[i] = 1'b0;
            end
        end

        for (int i = 0; i < NCH; i++) begin
            if (scan_idx_q == 3'(i)) begin
                sel_arm = arm_q[i];
                sel_cmp = cmp_q[i];
            end
        end

        case (state_q)
            INIT: begin
                cur_min_d = '1;
                state_d   = WR_HI1;
            end
            SCAN: begin
                if (sel_arm && (!found_q || sel_cmp < cur_min_q)) begin
                    cur_min_d = sel_cmp;
                    found_d   = 1'b1;
                    cur_ch_d  = scan_idx_q;
                end
                if (scan_idx_q == 3'(NCH-1)) state_d = WR_HI1;
                else                         scan_idx_d = scan_idx_q + 3'd1;
            end
            WR_HI1:  state_d = WR_LO;
            WR_LO:   state_d = WR_HI2;
            WR_HI2:  state_d = SETTLE1;
            SETTLE1: state_d = SETTLE2;
            SETTLE2: state_d = WAIT;
            WAIT: begin
                if (int_timer)                state_d = EXPIRE;
                else if (rescan_q || wr_trig) state_d = SCAN;
            end
            EXPIRE: begin
                for (int i = 0; i < NCH; i++) begin
                    if (arm_q[i] && cmp_q[i] <= cur_min_q) begin
                        pend_d[i] = 1'b1;
                        arm_d[i]  = 1'b0;
                    end
                end
                state_d = SCAN;
            end
            default: state_d = INIT;
        endcase

        // Every scan starts from a clean slate; writes arriving later are held.
        if (state_d == SCAN && state_q != SCAN) begin
            rescan_d   = 1'b0;
            cur_min_d  = '1;
            found_d    = 1'b0;
            cur_ch_d   = 3'd0;
            scan_idx_d = 3'd0;
        end

        case (state_d)
            WR_HI1: begin
                m_sel_d = 1'b1; m_we_d = 4'hF; m_addr_d = TMR_CMP_HI; m_wdata_d = '1;
            end
            WR_LO: begin
                m_sel_d = 1'b1; m_we_d = 4'hF; m_addr_d = TMR_CMP_LO;
                m_wdata_d = cur_min_d[XLEN-1:0];
            end
            WR_HI2: begin
                m_sel_d = 1'b1; m_we_d = 4'hF; m_addr_d = TMR_CMP_HI;
                m_wdata_d = cur_min_d[2*XLEN-1:XLEN];
            end
            default: ;
        endcase
    end

    // State, configuration registers and registered timer-bus outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= INIT;
            cmp_q      <= '{default: '0};
            arm_q      <= '0;
            pend_q     <= '0;
            ien_q      <= '0;
            rescan_q   <= 1'b0;
            cur_min_q  <= '1;
            found_q    <= 1'b0;
            cur_ch_q   <= 3'd0;
            scan_idx_q <= 3'd0;
            m_sel_q    <= 1'b0;
            m_addr_q   <= '0;
            m_we_q     <= 4'h0;
            m_wdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            cmp_q      <= cmp_d;
            arm_q      <= arm_d;
            pend_q     <= pend_d;
            ien_q      <= ien_d;
            rescan_q   <= rescan_d;
            cur_min_q  <= cur_min_d;
            found_q    <= found_d;
            cur_ch_q   <= cur_ch_d;
            scan_idx_q <= scan_idx_d;
            m_sel_q    <= m_sel_d;
            m_addr_q   <= m_addr_d;
            m_we_q     <= m_we_d;
            m_wdata_q  <= m_wdata_d;
        end
    end

endmodule

// File: tb/tb_timer_sched.sv
// Bench for timer_sched: directed scenarios followed by randomized
// configuration/expiry rounds, checked against a register-level model.
module tb_timer_sched;
    localparam int          NCH    = 4;
    localparam logic [15:0] A_LO   = 16'h4000;
    localparam logic [15:0] A_HI   = 16'h4004;
    localparam logic [7:0]  R_ARM  = 8'h40;
    localparam logic [7:0]  R_PEND = 8'h44;
    localparam logic [7:0]  R_IEN  = 8'h48;
    localparam logic [7:0]  R_STAT = 8'h4C;
    localparam logic [63:0] ONES   = 64'hFFFF_FFFF_FFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cfg_sel = 1'b0;
    logic [7:0]  cfg_addr = '0;
    logic [3:0]  cfg_we = '0;
    logic [31:0] cfg_wdata = '0;
    logic [31:0] cfg_rdata;
    logic        m_sel;
    logic [15:0] m_addr;
    logic [3:0]  m_we;
    logic [31:0] m_wdata;
    logic        int_timer = 1'b0;
    logic        int_sched;

    timer_sched #(.XLEN(32), .NCH(NCH), .TMR_CMP_LO(A_LO), .TMR_CMP_HI(A_HI)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_sel(cfg_sel), .cfg_addr(cfg_addr),
        .cfg_we(cfg_we), .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata),
        .m_sel(m_sel), .m_addr(m_addr), .m_we(m_we), .m_wdata(m_wdata),
        .int_timer(int_timer), .int_sched(int_sched)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0, n_pass = 0, n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Timer-side view: log every bus write and keep the resulting mtimecmp.
    typedef struct { logic [15:0] a; logic [31:0] d; int c; } wr_t;
    wr_t         wq[$];
    logic [63:0] mt = '0;

    // Watch the timer bus every cycle.
    always @(negedge clk) begin
        chk("m_we", {60'd0, m_we}, m_sel ? 64'hF : 64'h0);
        if (m_sel) begin
            wq.push_back('{a: m_addr, d: m_wdata, c: cyc});
            if (m_addr == A_LO)      mt[31:0]  = m_wdata;
            else if (m_addr == A_HI) mt[63:32] = m_wdata;
        end
    end

    // Register model
    logic [63:0]    cmp_m [NCH];
    logic [NCH-1:0] arm_m = '0, pend_m = '0, ien_m = '0;

    task automatic mdl_reset();
        for (int i = 0; i < NCH; i++) cmp_m[i] = '0;
        arm_m = '0; pend_m = '0; ien_m = '0;
    endtask

    task automatic mdl_wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] we);
        if (we != 4'h0) begin
            if (a[7:3] < NCH) begin
                int ch;
                ch = int'(a[5:3]);
                for (int b = 0; b < 4; b++)
                    if (we[b]) begin
                        if (a[2]) cmp_m[ch][32+8*b +: 8] = d[8*b +: 8];
                        else      cmp_m[ch][8*b +: 8]    = d[8*b +: 8];
                    end
            end else if (a[7:2] == 6'h10 && we[0]) arm_m = d[NCH-1:0];
            else if (a[7:2] == 6'h11 && we[0])    pend_m = pend_m & ~d[NCH-1:0];
            else if (a[7:2] == 6'h12 && we[0])    ien_m = d[NCH-1:0];
        end
    endtask

    // Earliest armed compare value (lowest channel on ties); all-ones if none.
    task automatic model_min(output logic [63:0] v, output int ch, output bit any);
        v = ONES; ch = 0; any = 0;
        for (int i = 0; i < NCH; i++)
            if (arm_m[i] && (!any || cmp_m[i] < v)) begin
                v = cmp_m[i]; ch = i; any = 1;
            end
    endtask

    task automatic cfg_start(input logic [7:0] a, input logic [31:0] d, input logic [3:0] we);
        cfg_sel = 1'b1; cfg_addr = a; cfg_wdata = d; cfg_we = we;
        mdl_wr(a, d, we);
    endtask

    task automatic cfg_end();
        @(posedge clk); @(negedge clk);
        cfg_sel = 1'b0; cfg_we = 4'h0;
    endtask

    task automatic cfg_wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] we);
        cfg_start(a, d, we);
        cfg_end();
    endtask

    task automatic cfg_rd(input logic [7:0] a, output logic [31:0] d);
        cfg_sel = 1'b1; cfg_addr = a; cfg_we = 4'h0;
        #1 d = cfg_rdata;
        cfg_sel = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int quiet;
        logic [31:0] s;
        quiet = 0;
        for (int k = 0; k < 300 && quiet < 2; k++) begin
            @(posedge clk); @(negedge clk);
            cfg_rd(R_STAT, s);
            if (!s[31]) quiet++; else quiet = 0;
        end
        chk({tag, "_idle"}, 64'(quiet >= 2), 64'd1);
    endtask

    // Called in the cycle that triggers programming; checks cycle by cycle.
    task automatic check_prog(input int nscan, input logic [63:0] v, input string tag);
        logic [31:0] s;
        for (int k = 1; k <= nscan + 6; k++) begin
            @(posedge clk); @(negedge clk);
            if (k == 1) begin cfg_sel = 1'b0; cfg_we = 4'h0; end
            cfg_rd(R_STAT, s);
            chk($sformatf("%s_sel_busy_c%0d", tag, k), {62'd0, m_sel, s[31]},
                {62'd0, (k >= nscan + 1 && k <= nscan + 3), (k < nscan + 6)});
            if (k == nscan + 1) chk({tag, "_wr_hi1"}, {m_addr, m_wdata}, {A_HI, 32'hFFFF_FFFF});
            if (k == nscan + 2) chk({tag, "_wr_lo"},  {m_addr, m_wdata}, {A_LO, v[31:0]});
            if (k == nscan + 3) chk({tag, "_wr_hi2"}, {m_addr, m_wdata}, {A_HI, v[63:32]});
        end
    endtask

    // One-cycle int_timer pulse while in WAIT; PEND changes two cycles later.
    task automatic pulse_expire(input string tag);
        logic [63:0]    v;
        int             ch;
        bit             any;
        logic [31:0]    r;
        logic [NCH-1:0] pend_old;
        model_min(v, ch, any);
        pend_old = pend_m;
        int_timer = 1'b1;
        @(posedge clk); @(negedge clk);
        int_timer = 1'b0;
        cfg_rd(R_PEND, r);
        chk({tag, "_pend_t1"}, 64'(r), 64'(pend_old));
        for (int i = 0; i < NCH; i++)
            if (arm_m[i] && cmp_m[i] <= v) begin
                pend_m[i] = 1'b1; arm_m[i] = 1'b0;
            end
        @(posedge clk); @(negedge clk);
        cfg_rd(R_PEND, r);
        chk({tag, "_pend_t2"}, 64'(r), 64'(pend_m));
        cfg_rd(R_ARM, r);
        chk({tag, "_arm"}, 64'(r), 64'(arm_m));
        chk({tag, "_int_sched"}, 64'(int_sched), 64'(|(pend_m & ien_m)));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r;
        logic [63:0] v;
        int          ch, t0;
        bit          any;
        logic [3:0]  we;

        mdl_reset();
        repeat (3) @(negedge clk);
        chk("rst_m_outputs", {11'd0, m_sel, m_we, m_addr, m_wdata}, 64'd0);
        chk("rst_int_sched", 64'(int_sched), 64'd0);
        chk("rst_rdata_nosel", 64'(cfg_rdata), 64'd0);
        cfg_rd(R_ARM, r);  chk("rst_arm", 64'(r), 64'd0);
        cfg_rd(8'h00, r);  chk("rst_cmp0", 64'(r), 64'd0);
        cfg_rd(R_STAT, r); chk("rst_status", 64'(r), 64'h8000_0000);

        // Reset release programs all-ones with exact timing
        rst_n = 1'b1;
        check_prog(0, ONES, "init");
        chk("init_mt", mt, ONES);

        // Unmapped address: reads 0, write ignored and no rescan
        cfg_wr(8'h20, 32'hDEAD_BEEF, 4'hF);
        cfg_rd(R_STAT, r); chk("unmapped_no_rescan", 64'(r[31]), 64'd0);
        cfg_rd(8'h20, r);  chk("unmapped_rd", 64'(r), 64'd0);
        cfg_rd(8'h50, r);  chk("unmapped_rd50", 64'(r), 64'd0);

        // Earliest of two armed channels
        cfg_wr(8'h10, 32'h100, 4'hF);
        cfg_wr(8'h08, 32'h80, 4'hF);
        wait_idle("cmp_setup");
        cfg_start(R_ARM, 32'b0110, 4'hF);
        check_prog(NCH, 64'h80, "arm");
        cfg_rd(R_STAT, r); chk("cur_ch1", 64'(r[2:0]), 64'd1);
        chk("arm_mt", mt, 64'h80);

        // Expiry of channel 1, interrupt and W1C
        cfg_wr(R_IEN, 32'b0010, 4'hF);
        pulse_expire("exp1");
        wait_idle("exp1");
        chk("exp1_mt", mt, 64'h100);
        cfg_wr(R_PEND, 32'b0010, 4'hF);
        cfg_rd(R_PEND, r); chk("w1c_pend", 64'(r), 64'd0);
        chk("w1c_int_sched", 64'(int_sched), 64'd0);

        // Two channels tying expire together
        cfg_wr(8'h00, 32'h200, 4'hF);
        cfg_wr(8'h18, 32'h200, 4'hF);
        cfg_wr(R_ARM, 32'b1001, 4'hF);
        wait_idle("tie");
        chk("tie_mt", mt, 64'h200);
        pulse_expire("tie");
        wait_idle("tie2");
        chk("tie_pend_1001", 64'(pend_m), 64'b1001);
        chk("tie_mt_ones", mt, ONES);
        cfg_wr(R_PEND, 32'hF, 4'hF);

        // CMP write during WR_LO: first sequence unchanged, second follows
        cfg_wr(R_ARM, 32'b0001, 4'hF);
        wait_idle("mid_setup");
        wq.delete();
        t0 = cyc;
        cfg_start(8'h00, 32'h300, 4'hF);
        cfg_end();
        repeat (NCH + 1) begin @(posedge clk); @(negedge clk); end
        chk("mid_in_wr_lo", {47'd0, m_sel, m_addr}, {47'd1, A_LO});
        cfg_start(8'h00, 32'h50, 4'hF);
        cfg_end();
        wait_idle("mid");
        chk("mid_nwr", 64'(wq.size()), 64'd6);
        if (wq.size() == 6) begin
            chk("mid_w0", {wq[0].a, wq[0].d}, {A_HI, 32'hFFFF_FFFF});
            chk("mid_w1", {wq[1].a, wq[1].d}, {A_LO, 32'h300});
            chk("mid_w2", {wq[2].a, wq[2].d}, {A_HI, 32'h0});
            chk("mid_w3", {wq[3].a, wq[3].d}, {A_HI, 32'hFFFF_FFFF});
            chk("mid_w4", {wq[4].a, wq[4].d}, {A_LO, 32'h50});
            chk("mid_w5", {wq[5].a, wq[5].d}, {A_HI, 32'h0});
            chk("mid_c1", 64'(wq[1].c - t0), 64'(NCH + 2));
            chk("mid_c4", 64'(wq[4].c - t0), 64'(2 * NCH + 8));
        end

        // int_timer during settle cycles after raising the compare is ignored
        cfg_start(8'h00, 32'h600, 4'hF);
        cfg_end();
        repeat (NCH + 2) begin @(posedge clk); @(negedge clk); end
        int_timer = 1'b1;
        repeat (3) begin @(posedge clk); @(negedge clk); end
        int_timer = 1'b0;
        wait_idle("settle");
        cfg_rd(R_PEND, r); chk("settle_pend", 64'(r), 64'd0);
        cfg_rd(R_ARM, r);  chk("settle_arm", 64'(r), 64'b0001);
        chk("settle_mt", mt, 64'h600);

        // Reset in the middle of a programming sequence
        cfg_start(8'h00, 32'h700, 4'hF);
        cfg_end();
        repeat (NCH) begin @(posedge clk); @(negedge clk); end
        #2 rst_n = 1'b0;
        #1;
        chk("mrst_m_outputs", {11'd0, m_sel, m_we, m_addr, m_wdata}, 64'd0);
        cfg_rd(R_ARM, r); chk("mrst_arm", 64'(r), 64'd0);
        mdl_reset();
        @(negedge clk);
        rst_n = 1'b1;
        check_prog(0, ONES, "mrst");

        // Randomized rounds
        for (int it = 0; it < 15; it++) begin
            for (int i = 0; i < NCH; i++) begin
                if ($urandom_range(0, 1) == 1) begin
                    we = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'hF;
                    cfg_wr(8'(8 * i), 32'($urandom_range(0, 3)) * 32'h10 + 32'($urandom_range(0, 1)) * 32'h0101_0000, we);
                    cfg_wr(8'(8 * i + 4), 32'($urandom_range(0, 1)), 4'hF);
                end
            end
            cfg_wr(R_ARM, 32'($urandom_range(0, (1 << NCH) - 1)), 4'hF);
            cfg_wr(R_IEN, 32'($urandom_range(0, (1 << NCH) - 1)), 4'hF);
            wait_idle($sformatf("rnd%0d", it));
            model_min(v, ch, any);
            chk($sformatf("rnd%0d_mt", it), mt, v);
            if (any) begin
                cfg_rd(R_STAT, r);
                chk($sformatf("rnd%0d_cur_ch", it), 64'(r[2:0]), 64'(ch));
            end
            ch = $urandom_range(0, NCH - 1);
            cfg_rd(8'(8 * ch), r);
            chk($sformatf("rnd%0d_cmp_lo", it), 64'(r), 64'(cmp_m[ch][31:0]));
            cfg_rd(8'(8 * ch + 4), r);
            chk($sformatf("rnd%0d_cmp_hi", it), 64'(r), 64'(cmp_m[ch][63:32]));
            pulse_expire($sformatf("rnd%0d", it));
            wait_idle($sformatf("rnd%0d_post", it));
            model_min(v, ch, any);
            chk($sformatf("rnd%0d_mt_post", it), mt, v);
            cfg_wr(R_PEND, 32'($urandom_range(0, (1 << NCH) - 1)), 4'hF);
            cfg_rd(R_PEND, r);
            chk($sformatf("rnd%0d_w1c", it), 64'(r), 64'(pend_m));
            chk($sformatf("rnd%0d_int_sched", it), 64'(int_sched), 64'(|(pend_m & ien_m)));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
